// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer
// Buffers the view-stage pixel stream (X, Y, RGB444, strobe) in a small FIFO.
// Each pixel is converted to a linear framebuffer address (Y*SCREEN_W + X)
// on entry. Entries drain onto the framebuffer write port whenever it is not
// busy. Pixels lost to a full FIFO or to clipping are counted for debug.
//
// Optional feature macro: PWB_CLIP_EN
//   defined   -> pixels with X >= SCREEN_W or Y >= SCREEN_H are discarded
//                and counted in clip_count (clip wins over the full check)
//   undefined -> every pixel is pushed, the address is truncated to 17 bits,
//                and clip_count is tied to 0
module pixel_write_buffer #(
    parameter int DEPTH    = 16,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  X_in,
    input  logic [7:0]  Y_in,
    input  logic [11:0] Color_in,
    input  logic        writeEn_in,
    input  logic        fb_busy,
    input  logic        clear_stats,
    output logic [16:0] fb_addr,
    output logic [11:0] fb_data,
    output logic        fb_we,
    output logic        full,
    output logic        empty,
    output logic        overflow,
    output logic [7:0]  drop_count,
    output logic [7:0]  clip_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LP_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [16:0] LP_W    = 17'(SCREEN_W);

    // Geometry and depth sanity checks at elaboration time
    if ((DEPTH < 4) || (DEPTH > 64) || ((1 << AW) != DEPTH)) begin : g_bad_depth
        $error("pixel_write_buffer: DEPTH must be a power of two in 4..64");
    end
    if (SCREEN_W * SCREEN_H > 131072) begin : g_bad_geom
        $error("pixel_write_buffer: SCREEN_W*SCREEN_H exceeds 17-bit address space");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_NONEMPTY,
        S_FULL
    } state_t;

    state_t      r_state;
    logic [AW:0] r_count;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [28:0] r_mem [DEPTH];
    logic        r_full;
    logic        r_empty;
    logic        r_fb_we;
    logic [16:0] r_fb_addr;
    logic [11:0] r_fb_data;
    logic        r_overflow;
    logic [7:0]  r_drop_count;

    logic        w_inrange;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic [16:0] w_addr;

`ifdef PWB_CLIP_EN
    logic        w_clip;
    logic [7:0]  r_clip_count;

    assign w_inrange = (32'(X_in) < SCREEN_W) && (32'(Y_in) < SCREEN_H);
    assign w_clip    = writeEn_in && !w_inrange;
`else
    assign w_inrange = 1'b1;
`endif

    // Address is formed in 17 bits so an unchecked pixel simply wraps
    assign w_addr = (17'(Y_in) * LP_W) + 17'(X_in);

    // A pop frees a slot on the same edge, so a full FIFO can still accept
    assign w_pop  = !r_empty && !fb_busy;
    assign w_push = writeEn_in && w_inrange && (!r_full || w_pop);
    assign w_drop = writeEn_in && w_inrange && r_full && !w_pop;

    // Storage array: data path only, contents are meaningless when not counted
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_addr, Color_in};
        end
    end

    // Pointer advance; both wrap naturally modulo DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Occupancy FSM with registered full/empty flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_push) begin
                        r_count <= r_count + 1'b1;
                        r_empty <= 1'b0;
                        r_state <= S_NONEMPTY;
                    end
                end
                S_NONEMPTY: begin
                    if (w_push && !w_pop) begin
                        r_count <= r_count + 1'b1;
                        if (r_count == LP_LAST) begin
                            r_full  <= 1'b1;
                            r_state <= S_FULL;
                        end
                    end else if (w_pop && !w_push) begin
                        r_count <= r_count - 1'b1;
                        if (r_count == 1) begin
                            r_empty <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_FULL: begin
                    if (w_pop && !w_push) begin
                        r_count <= r_count - 1'b1;
                        r_full  <= 1'b0;
                        r_state <= S_NONEMPTY;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_count <= '0;
                    r_full  <= 1'b0;
                    r_empty <= 1'b1;
                end
            endcase
        end
    end

    // Framebuffer port: head entry registered on a pop, held otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= '0;
        end else begin
            r_fb_we <= w_pop;
            if (w_pop) begin
                r_fb_addr <= r_mem[r_rptr][28:12];
                r_fb_data <= r_mem[r_rptr][11:0];
            end
        end
    end

    // Drop statistics; clear_stats overrides a same-edge increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (clear_stats) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 1'b1;
        end
    end

`ifdef PWB_CLIP_EN
    // Clip statistics; clear_stats overrides a same-edge increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clip_count <= '0;
        end else if (clear_stats) begin
            r_clip_count <= '0;
        end else if (w_clip && (r_clip_count != 8'hFF)) begin
            r_clip_count <= r_clip_count + 1'b1;
        end
    end

    assign clip_count = r_clip_count;
`else
    assign clip_count = 8'd0;
`endif

    assign fb_addr    = r_fb_addr;
    assign fb_data    = r_fb_data;
    assign fb_we      = r_fb_we;
    assign full       = r_full;
    assign empty      = r_empty;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed self-checking bench for pixel_write_buffer (DEPTH 16, 320x240).
// Honors PWB_CLIP_EN the same way the design does.
module tb_pixel_write_buffer;

    logic        clk;
    logic        reset;
    logic [8:0]  X_in;
    logic [7:0]  Y_in;
    logic [11:0] Color_in;
    logic        writeEn_in;
    logic        fb_busy;
    logic        clear_stats;
    logic [16:0] fb_addr;
    logic [11:0] fb_data;
    logic        fb_we;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [7:0]  clip_count;

    int checks = 0;
    int errors = 0;

    pixel_write_buffer #(.DEPTH(16), .SCREEN_W(320), .SCREEN_H(240)) dut (
        .clk(clk), .reset(reset), .X_in(X_in), .Y_in(Y_in), .Color_in(Color_in),
        .writeEn_in(writeEn_in), .fb_busy(fb_busy), .clear_stats(clear_stats),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .full(full),
        .empty(empty), .overflow(overflow), .drop_count(drop_count),
        .clip_count(clip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle 1 time unit for sampling and driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        writeEn_in  = 1'b0;
        clear_stats = 1'b0;
        X_in = '0; Y_in = '0; Color_in = '0;
    endtask

    task automatic drive_pix(input int x, input int y, input int c);
        writeEn_in = 1'b1;
        X_in = 9'(x); Y_in = 8'(y); Color_in = 12'(c);
    endtask

    task automatic flush_with_reset();
        idle_inputs();
        fb_busy = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        fb_busy = 1'b0;
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({fb_addr, fb_data, fb_we, full, empty, overflow, drop_count, clip_count} !==
            {17'd0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_values got addr=%0d data=%h we=%b full=%b empty=%b ovf=%b drop=%0d clip=%0d want 0,0,0,0,1,0,0,0",
                     fb_addr, fb_data, fb_we, full, empty, overflow, drop_count, clip_count);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        logic [16:0] exp_addr [3];
        logic [11:0] exp_col [3];
        exp_addr[0] = 17'd25610; exp_addr[1] = 17'd25611; exp_addr[2] = 17'd25612;
        exp_col[0] = 12'hF00; exp_col[1] = 12'h0F0; exp_col[2] = 12'h00F;
        fb_busy = 1'b0;
        drive_pix(10, 80, 'hF00);
        tick();
        checks++;
        if (empty !== 1'b0 || fb_we !== 1'b0) begin
            errors++;
            $display("FAIL stream_first_edge got empty=%b we=%b want 0 0", empty, fb_we);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive_pix(11, 80, 'h0F0);
            else if (i == 1) drive_pix(12, 80, 'h00F);
            else idle_inputs();
            tick();
            checks++;
            if (fb_we !== 1'b1 || fb_addr !== exp_addr[i] || fb_data !== exp_col[i]) begin
                errors++;
                $display("FAIL stream_write%0d got we=%b addr=%0d data=%h want 1 %0d %h",
                         i, fb_we, fb_addr, fb_data, exp_addr[i], exp_col[i]);
            end
        end
        tick();
        checks++;
        if (fb_we !== 1'b0 || empty !== 1'b1 || fb_addr !== 17'd25612) begin
            errors++;
            $display("FAIL stream_end got we=%b empty=%b addr=%0d want 0 1 25612", fb_we, empty, fb_addr);
        end
    endtask

    task automatic test_full_drop();
        int writes;
        int bad;
        idle_inputs();
        clear_stats = 1'b1; tick(); clear_stats = 1'b0;
        fb_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_pix(i, 1, 'h100 + i);
            tick();
            if (i == 15) begin
                checks++;
                if (full !== 1'b1 || drop_count !== 8'd0) begin
                    errors++;
                    $display("FAIL full_after16 got full=%b drop=%0d want 1 0", full, drop_count);
                end
            end
        end
        checks++;
        if (full !== 1'b1 || overflow !== 1'b1 || drop_count !== 8'd4 || fb_we !== 1'b0) begin
            errors++;
            $display("FAIL full_drops got full=%b ovf=%b drop=%0d we=%b want 1 1 4 0",
                     full, overflow, drop_count, fb_we);
        end
        idle_inputs();
        fb_busy = 1'b0;
        writes = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fb_we) begin
                if (fb_addr !== 17'(320 + writes) || fb_data !== 12'(16'h100 + writes)) bad++;
                writes++;
            end
        end
        checks++;
        if (writes != 16 || bad != 0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL drain_order got writes=%0d bad=%0d empty=%b full=%b want 16 0 1 0",
                     writes, bad, empty, full);
        end
    endtask

    task automatic test_full_push_pop();
        logic [16:0] last_addr;
        int writes;
        idle_inputs();
        clear_stats = 1'b1; tick(); clear_stats = 1'b0;
        fb_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_pix(i, 2, i);
            tick();
        end
        fb_busy = 1'b0;
        drive_pix(100, 3, 'hABC);
        tick();
        checks++;
        if (full !== 1'b1 || drop_count !== 8'd0 || fb_we !== 1'b1 || fb_addr !== 17'd640) begin
            errors++;
            $display("FAIL full_push_pop got full=%b drop=%0d we=%b addr=%0d want 1 0 1 640",
                     full, drop_count, fb_we, fb_addr);
        end
        idle_inputs();
        writes = 0; last_addr = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fb_we) begin
                writes++;
                last_addr = fb_addr;
            end
        end
        checks++;
        if (writes != 16 || last_addr !== 17'd1060 || fb_data !== 12'hABC || empty !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop_drain got writes=%0d last=%0d data=%h empty=%b want 16 1060 abc 1",
                     writes, last_addr, fb_data, empty);
        end
    endtask

    task automatic test_clip();
        int writes;
        logic [16:0] a0;
        logic [16:0] a1;
        idle_inputs();
        clear_stats = 1'b1; tick(); clear_stats = 1'b0;
        fb_busy = 1'b0;
        writes = 0; a0 = '0; a1 = '0;
        drive_pix(320, 10, 'h123);
        tick();
        drive_pix(5, 240, 'h456);
        tick();
        if (fb_we) begin a0 = fb_addr; writes++; end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            if (fb_we) begin
                if (writes == 0) a0 = fb_addr; else a1 = fb_addr;
                writes++;
            end
        end
`ifdef PWB_CLIP_EN
        checks++;
        if (writes != 0 || clip_count !== 8'd2 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL clip_discard got writes=%0d clip=%0d drop=%0d want 0 2 0",
                     writes, clip_count, drop_count);
        end
`else
        checks++;
        if (writes != 2 || a0 !== 17'd3520 || a1 !== 17'd76805 || clip_count !== 8'd0) begin
            errors++;
            $display("FAIL noclip_addr got writes=%0d a0=%0d a1=%0d clip=%0d want 2 3520 76805 0",
                     writes, a0, a1, clip_count);
        end
`endif
    endtask

    task automatic test_reset_midstream();
        int writes;
        idle_inputs();
        fb_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_pix(i, 7, 'h700 + i);
            tick();
        end
        idle_inputs();
        fb_busy = 1'b0;
        reset = 1'b1;
        tick();
        checks++;
        if (empty !== 1'b1 || fb_we !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_midstream got empty=%b we=%b full=%b want 1 0 0", empty, fb_we, full);
        end
        reset = 1'b0;
        writes = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (fb_we) writes++;
        end
        checks++;
        if (writes != 0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_stale got writes=%0d empty=%b want 0 1", writes, empty);
        end
    endtask

    task automatic test_saturation();
        idle_inputs();
        fb_busy = 1'b1;
        for (int i = 0; i < 316; i++) begin
            drive_pix(1, 1, 'h111);
            tick();
        end
        checks++;
        if (drop_count !== 8'd255 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drop_saturate got drop=%0d ovf=%b want 255 1", drop_count, overflow);
        end
        clear_stats = 1'b1;
        tick();
        checks++;
        if (drop_count !== 8'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_over_drop got drop=%0d ovf=%b want 0 0", drop_count, overflow);
        end
        clear_stats = 1'b0;
        tick();
        checks++;
        if (drop_count !== 8'd1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drop_after_clear got drop=%0d ovf=%b want 1 1", drop_count, overflow);
        end
        idle_inputs();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        checks++;
        if (drop_count !== 8'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_stats got drop=%0d ovf=%b want 0 0", drop_count, overflow);
        end
        flush_with_reset();
    endtask

    initial begin
        reset = 1'b1;
        fb_busy = 1'b0;
        idle_inputs();
        test_reset();
        test_stream();
        test_full_drop();
        test_full_push_pop();
        test_clip();
        test_reset_midstream();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
